seq_detect_prog: RTL

Runtime-programmable serial sequence detector. It is the parametrised successor to the fixed 101010 Mealy detector.
- Compares a qualified bit stream against a loadable pattern of 1..MAX_LEN bits.
- Selectable overlapping or non-overlapping detection.
- Provides a combinational Mealy match, a registered match and a saturating match counter.
- Sits on the serial receive path; the reset configuration reproduces the legacy 101010 overlapping behaviour.

---
 rtl/seq_detect_prog.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial sequence detector.
//
// Compares the qualified serial stream against a loadable pattern of 1..MAX_LEN
// bits, with overlapping or non-overlapping detection. The reset configuration
// reproduces the legacy 101010 overlapping detector.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in           serial data bit
//   in_valid     qualifies in; the stream only advances when high
//   cfg_load     one-cycle strobe latching cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  pattern, bit[len-1] received first, bit[0] received last
//   cfg_len      pattern length, legal 1..MAX_LEN
//   cfg_overlap  1 = overlapping, 0 = non-overlapping detection
//   clr_count    synchronous clear of match_count (wins over a same-cycle match)
//   match        Mealy match, combinational, same cycle as the final bit
//   match_q      match delayed by one cycle
//   match_count  saturating match counter
//   fill         number of valid history bits, saturating at len-1
//   cfg_err      active configuration is illegal; detector disabled
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'b0010_1010),
    parameter int                 DEFAULT_LEN = 6,
    parameter bit                 DEFAULT_OVL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               match,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    logic               err_r;
    logic [MAX_LEN-2:0] hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               match_q_r;

    logic               accept;
    logic [LEN_W-1:0]   len_m1;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               hit;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [LEN_W-1:0] fill_sat_inc(input logic [LEN_W-1:0] f,
                                                      input logic [LEN_W-1:0] lim);
        return (f >= lim) ? lim : f + LEN_W'(1);
    endfunction

    // A load cycle consumes the strobe, so the same-cycle bit is discarded.
    assign accept = in_valid & ~cfg_load & ~err_r;
    assign len_m1 = len_r - LEN_W'(1);
    assign window = {hist_r, in};

    // Only the low len bits of the pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_r));
        end
    end

    assign hit   = (((window ^ pat_r) & mask) == '0);
    assign match = ~reset & accept & (fill_r >= len_m1) & hit;

    // Configuration and history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_r  <= DEFAULT_PAT;
            len_r  <= LEN_W'(DEFAULT_LEN);
            ovl_r  <= DEFAULT_OVL;
            err_r  <= 1'b0;
            hist_r <= '0;
            fill_r <= '0;
        end else if (cfg_load) begin
            pat_r  <= cfg_pattern;
            len_r  <= cfg_len;
            ovl_r  <= cfg_overlap;
            err_r  <= (cfg_len == '0) || (int'(cfg_len) > MAX_LEN);
            hist_r <= '0;
            fill_r <= '0;
        end else if (accept) begin
            if (match && !ovl_r) begin
                // Non-overlapping: the next match needs len fresh bits.
                hist_r <= '0;
                fill_r <= '0;
            end else begin
                // In overlap mode fill simply stays pinned at len-1 after a match.
                hist_r <= window[MAX_LEN-2:0];
                fill_r <= fill_sat_inc(fill_r, len_m1);
            end
        end
    end

    // Registered match and counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            match_q_r <= match;
            if (clr_count) begin
                cnt_r <= '0;
            end else if (match) begin
                cnt_r <= cnt_sat_inc(cnt_r);
            end
        end
    end

    assign match_q     = match_q_r;
    assign match_count = cnt_r;
    assign fill        = fill_r;
    assign cfg_err     = err_r;

endmodule
